// File: rtl/spi_controller.sv
// ============================================================================
//  Module   : spi_controller
//  Purpose  : SPI mode-0 write-only controller; sends {1,000,addr} then data
//             as two nCS-framed MSB-first bytes. Optional macro:
//             SPI_ADDR_CHECK_EN (reject addresses above 4 with an err pulse).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS
);

    localparam int c_MAX_PHASE = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_CNT_W     = $clog2(c_MAX_PHASE) + 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(CS_GAP - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEAD = 3'd1;
    localparam logic [2:0] c_HIGH = 3'd2;
    localparam logic [2:0] c_LOW  = 3'd3;
    localparam logic [2:0] c_TAIL = 3'd4;
    localparam logic [2:0] c_GAP  = 3'd5;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic               r_frame, w_frame_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_ncs, w_ncs_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               r_copi, w_copi_nxt;
    logic               r_req_ready, w_req_ready_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic w_accept;
    logic w_reject;
    logic w_div_last;
    logic w_gap_last;

    assign w_accept   = (r_state == c_IDLE) && req_valid && r_req_ready;
    assign w_div_last = (r_cnt == c_DIV_LAST);
    assign w_gap_last = (r_cnt == c_GAP_LAST);

`ifdef SPI_ADDR_CHECK_EN
    assign w_reject = w_accept && (req_addr > 4'd4);
`else
    assign w_reject = 1'b0;
`endif

    // State and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= 3'd0;
            r_frame     <= 1'b0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_ncs       <= 1'b1;
            r_sclk      <= 1'b0;
            r_copi      <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_frame     <= w_frame_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_ncs       <= w_ncs_nxt;
            r_sclk      <= w_sclk_nxt;
            r_copi      <= w_copi_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept && !w_reject) w_state_nxt = c_LEAD;
            c_LEAD: if (w_div_last) w_state_nxt = c_HIGH;
            c_HIGH: if (w_div_last) w_state_nxt = (r_bit_cnt == 3'd7) ? c_TAIL : c_LOW;
            c_LOW:  if (w_div_last) w_state_nxt = c_HIGH;
            c_TAIL: if (w_div_last) w_state_nxt = c_GAP;
            c_GAP:  if (w_gap_last) w_state_nxt = r_frame ? c_IDLE : c_LEAD;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt       = (r_state == c_IDLE || w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_frame_nxt     = r_frame;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_ncs_nxt       = r_ncs;
        w_sclk_nxt      = r_sclk;
        w_copi_nxt      = r_copi;
        w_req_ready_nxt = r_req_ready;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Ready returns one cycle after done/err, so no accept overlaps them.
                w_req_ready_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
                if (w_reject) begin
                    w_err_nxt       = 1'b1;
                    w_req_ready_nxt = 1'b0;
                end else if (w_accept) begin
                    w_ncs_nxt       = 1'b0;
                    w_shift_nxt     = {4'b1000, req_addr};
                    w_copi_nxt      = 1'b1;
                    w_data_nxt      = req_data;
                    w_frame_nxt     = 1'b0;
                    w_bit_cnt_nxt   = 3'd0;
                    w_req_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            c_LEAD, c_LOW: begin
                if (w_div_last) w_sclk_nxt = 1'b1;
            end
            c_HIGH: begin
                if (w_div_last) begin
                    w_sclk_nxt    = 1'b0;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt != 3'd7) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_copi_nxt  = r_shift[6];
                    end
                end
            end
            c_TAIL: begin
                if (w_div_last) begin
                    w_ncs_nxt  = 1'b1;
                    w_copi_nxt = 1'b0;
                end
            end
            c_GAP: begin
                if (w_gap_last) begin
                    if (!r_frame) begin
                        w_shift_nxt = r_data;
                        w_copi_nxt  = r_data[7];
                        w_ncs_nxt   = 1'b0;
                        w_frame_nxt = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_frame_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_ncs_nxt  = 1'b1;
                w_sclk_nxt = 1'b0;
                w_copi_nxt = 1'b0;
            end
        endcase
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign SCLK      = r_sclk;
    assign COPI      = r_copi;
    assign nCS       = r_ncs;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
//  Module   : tb_spi_controller
//  Purpose  : Scoreboard bench for spi_controller; frames captured on SCLK
//             rising edges are compared against bytes queued at request time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_controller;

    localparam int c_CLK_DIV   = 4;
    localparam int c_CS_GAP    = 4;
    localparam int c_FRAME_LEN = 17 * c_CLK_DIV;
    localparam int c_DONE_LAT  = 2 * (c_FRAME_LEN + c_CS_GAP);
    localparam int c_WAIT_MAX  = 4 * c_DONE_LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic [7:0] req_data = 8'd0;
    logic       req_ready, busy, done, err, SCLK, COPI, nCS;

    spi_controller #(
        .CLK_DIV (c_CLK_DIV),
        .CS_GAP  (c_CS_GAP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    logic [7:0] exp_q[$];
    int exp_done = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int fall_cnt = 0;

    logic       prev_ncs  = 1'b1;
    logic       prev_sclk = 1'b0;
    logic [7:0] mon_sh    = 8'd0;
    int         nbits = 0, frames_in_txn = 0;
    int         fall_cyc = 0, rise_cyc = 0, t0 = 0;
    bit         aborted = 1'b0;

    // Pin monitor: rebuilds bytes from the bus and scores them.
    always @(negedge clk) begin
        int qs;
        if (!rst && nCS) begin
            check("idle_sclk", SCLK, 0);
            check("idle_copi", COPI, 0);
        end
        if (prev_ncs && !nCS) begin
            fall_cnt++;
            if (frames_in_txn == 0) t0 = cyc;
            else check("cs_gap", cyc - rise_cyc, c_CS_GAP);
            fall_cyc = cyc;
            nbits    = 0;
            mon_sh   = 8'd0;
        end
        if (!nCS && !prev_sclk && SCLK) begin
            mon_sh = {mon_sh[6:0], COPI};
            nbits++;
        end
        if (!prev_ncs && nCS) begin
            if (aborted) begin
                aborted = 1'b0;
            end else begin
                rise_cyc = cyc;
                frames_in_txn++;
                check("sclk_edges", nbits, 8);
                check("frame_len", cyc - fall_cyc, c_FRAME_LEN);
                qs = exp_q.size();
                check("frame_expected", int'(qs > 0), 1);
                if (qs > 0) check("frame_data", mon_sh, exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            check("done_latency", cyc - t0, c_DONE_LAT);
            check("frames_per_txn", frames_in_txn, 2);
            frames_in_txn = 0;
        end
        if (err) err_cnt++;
        prev_ncs  = nCS;
        prev_sclk = SCLK;
        if (rst) begin
            aborted       = !nCS;
            nbits         = 0;
            frames_in_txn = 0;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < c_WAIT_MAX; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("ready_seen", req_ready, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < c_WAIT_MAX; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", done, 1);
    endtask

    task automatic start_write(input logic [3:0] a, input logic [7:0] d);
        wait_ready();
        exp_q.push_back({4'b1000, a});
        exp_q.push_back(d);
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", req_ready, 0);
    endtask

    initial begin
        int falls_before;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ncs", nCS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_copi", COPI, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single write with handshake timing around done.
        start_write(4'd2, 8'hA5);
        exp_done++;
        wait_done();
        check("ready_at_done", req_ready, 0);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("ready_after_done", req_ready, 1);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);

        // Back-to-back with req_valid held high.
        wait_ready();
        exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h84); exp_q.push_back(8'h80);
        exp_done += 2;
        req_addr = 4'd0; req_data = 8'hFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_addr = 4'd4; req_data = 8'h80;
        wait_done();
        check("b2b_ready_at_done", req_ready, 0);
        @(negedge clk);
        check("b2b_ready_after_done", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_accepted", busy, 1);
        wait_done();

        // Request while busy must be dropped.
        start_write(4'd3, 8'h3C);
        exp_done++;
        repeat (20) @(negedge clk);
        req_addr = 4'd1; req_data = 8'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done();
        repeat (60) @(negedge clk);

        // Reset while SCLK is high inside the data frame.
        start_write(4'd3, 8'h5A);
        for (int i = 0; i < c_WAIT_MAX; i++) begin
            @(negedge clk);
            if (frames_in_txn == 1 && !nCS && SCLK && nbits == 5) break;
        end
        check("reached_bit3", nbits, 5);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ncs", nCS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_copi", COPI, 0);
        check("abort_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        exp_q.delete();
        start_write(4'd2, 8'hC3);
        exp_done++;
        wait_done();

        // Out-of-range address.
`ifdef SPI_ADDR_CHECK_EN
        wait_ready();
        falls_before = fall_cnt;
        req_addr = 4'd7; req_data = 8'h21; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("reject_err", err, 1);
        check("reject_ready", req_ready, 0);
        @(negedge clk);
        check("reject_err_clear", err, 0);
        check("reject_ready_back", req_ready, 1);
        repeat (40) @(negedge clk);
        check("reject_no_frames", fall_cnt, falls_before);
        check("err_count", err_cnt, 1);
`else
        falls_before = fall_cnt;
        start_write(4'd7, 8'h21);
        exp_done++;
        wait_done();
        check("addr7_frames", fall_cnt - falls_before, 2);
        check("err_count", err_cnt, 0);
`endif

        repeat (60) @(negedge clk);
        check("frames_left", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
